// File: rtl/wb_cmd_pkg.sv
// wb_cmd_master shared types and default parameter values.
// FSM state encoding used by the command master.
package wb_cmd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 32;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;

    // Width of the packed FIFO entry {we, adr, dat}.
    function automatic int cmd_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master port bundle: command push, response, Wishbone bus, interrupt.
// master = design view, slave = environment view.
interface wb_cmd_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_adr;
    logic [DATA_W-1:0] cmd_dat;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_dat;
    logic              rsp_err;

    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_we_o;
    logic              wb_stb_o;
    logic              wb_cyc_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;
    logic              wb_int_i;

    logic              irq_pulse;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat,
        input  wb_dat_i, wb_ack_i, wb_int_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output irq_pulse
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat,
        output wb_dat_i, wb_ack_i, wb_int_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  irq_pulse
    );

endinterface

// File: rtl/wb_cmd_fifo.sv
// Command FIFO for wb_cmd_master; power-of-2 depth, pointers wrap naturally.
// ready depends only on occupancy, so a full FIFO never passes through.
module wb_cmd_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         ready,
    output logic         not_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign ready     = (count_q < CW'(DEPTH));
    assign not_empty = (count_q != '0);
    assign push_ok   = push & ready;
    assign pop_ok    = pop & not_empty;
    assign rdata     = mem[rptr_q];

    // Pointer and occupancy update; push+pop together leaves count unchanged.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Queued single-transfer Wishbone master with one-cycle response pulse.
// Define WB_TIMEOUT_EN to add the bus-phase timeout abort path.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    wb_cmd_master_if.master bus
);

    localparam int W = cmd_w(ADDR_W, DATA_W);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1))
    begin : g_bad_cfg
        $error("wb_cmd_master: DEPTH must be a power of 2 >= 2, TIMEOUT >= 1");
    end

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
    logic              int_q, int_d;
    logic              irq_q, irq_d;

    logic              push;
    logic              pop;
    logic              fifo_ready;
    logic              fifo_ne;
    logic [W-1:0]      head;

`ifdef WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              rsp_err_q, rsp_err_d;
`endif

    assign push = bus.cmd_valid & fifo_ready;

    wb_cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (wb_clk),
        .rst_n     (wb_rst_n),
        .push      (push),
        .wdata     ({bus.cmd_we, bus.cmd_adr, bus.cmd_dat}),
        .pop       (pop),
        .rdata     (head),
        .ready     (fifo_ready),
        .not_empty (fifo_ne)
    );

    assign bus.cmd_ready = fifo_ready;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.irq_pulse = irq_q;
`ifdef WB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    // Next state and bus outputs: launch head in IDLE, finish on ack/expiry.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = '0;
        pop         = 1'b0;
`ifdef WB_TIMEOUT_EN
        tmo_d       = tmo_q;
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (fifo_ne) begin
                    pop                 = 1'b1;
                    state_d             = BUS;
                    cyc_d               = 1'b1;
                    stb_d               = 1'b1;
                    {we_d, adr_d, dat_d} = head;
`ifdef WB_TIMEOUT_EN
                    tmo_d               = '0;
`endif
                end
            end
            BUS: begin
                if (bus.wb_ack_i) begin
                    state_d     = IDLE;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : bus.wb_dat_i;
`ifdef WB_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = IDLE;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d       = tmo_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Interrupt edge detector: pulse when the registered level was low.
    always_comb begin
        int_d = bus.wb_int_i;
        irq_d = bus.wb_int_i & ~int_q;
    end

    // State and output registers; reset aborts any transfer silently.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            int_q       <= 1'b0;
            irq_q       <= 1'b0;
`ifdef WB_TIMEOUT_EN
            tmo_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            int_q       <= int_d;
            irq_q       <= irq_d;
`ifdef WB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

endmodule
